instr_mem_ctrl: RTL and testbench

//  Parametrised instruction-memory controller for the core fetch port.

---
 rtl/instr_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// instr_mem_ctrl
//
// Instruction-memory controller for the core fetch port. One byte address
// space is decoded into NUM_BANKS single-port RAM banks (contiguous or
// word-interleaved) plus a boot ROM selected by the address MSB. The core sees
// a req/gnt/rvalid handshake: RAM, write and error responses arrive one cycle
// after the grant, and ROM reads take ROM_WAIT extra cycles. During those extra
// cycles gnt_o is held low. ROM writes and RAM addresses with nonzero unused
// upper bits are granted and answered with err_o.
//
// The banks and the boot ROM are behavioural models held in this file. They
// stand in for the sp_ram_wrap / boot_rom_wrap instances. The ROM image is a
// fixed pattern: word = 32'hB007_0000 ^ ROM word index.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req_i         access request
//   gnt_o         request accepted this cycle (req_i & gnt_o = transfer)
//   addr_i        byte address, word aligned; MSB selects the boot ROM
//   we_i, be_i    write enable, byte enables
//   wdata_i       write data
//   rvalid_o      single-cycle response pulse, one per granted request
//   rdata_o       read data; 0 for writes, errors and when rvalid_o=0
//   err_o         response is an error; 0 when rvalid_o=0
//   bypass_en_i   test bypass, forwarded to every bank
// -----------------------------------------------------------------------------
module instr_mem_ctrl #(
    parameter int NUM_BANKS      = 2,
    parameter int BANK_SIZE      = 65536,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(NUM_BANKS * BANK_SIZE) + 1,
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int ROM_WAIT       = 2,
    parameter int INTERLEAVE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    bypass_en_i
);

    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int WOFF       = $clog2(BE_W);                 // byte-in-word bits
    localparam int BANK_AW    = $clog2(BANK_SIZE);            // byte bits per bank
    localparam int BSEL_BITS  = $clog2(NUM_BANKS);
    localparam int BSEL_W     = (NUM_BANKS > 1) ? BSEL_BITS : 1;
    localparam int MAP_W      = $clog2(NUM_BANKS * BANK_SIZE); // mapped RAM byte bits
    localparam int LOCAL_AW   = BANK_AW - WOFF;               // word bits per bank
    localparam int BANK_WORDS = BANK_SIZE / BE_W;

    typedef enum logic {
        ST_IDLE,
        ST_ROM_WAIT
    } state_t;

    // Where the registered response takes its data from.
    typedef enum logic [1:0] {
        SRC_ZERO,   // write response
        SRC_BANK,   // RAM read, bank selected by bank_sel_q
        SRC_ROM,    // ROM read
        SRC_ERR     // ROM write or unmapped address
    } src_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rvalid_q, rvalid_d;
    src_t                src_q, src_d;
    logic [BSEL_W-1:0]   bank_sel_q, bank_sel_d;

    logic                is_rom;
    logic                unmapped;
    logic [BSEL_W-1:0]   bank_idx;
    logic [LOCAL_AW-1:0] local_addr;

    logic [NUM_BANKS-1:0]  bank_en;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  rom_en;
    logic [DATA_WIDTH-1:0] rom_word;
    logic [DATA_WIDTH-1:0] rom_rdata_q;

    // The word-offset bits carry no information for aligned fetches. The
    // behavioural bank models have no test-bypass path.
    logic unused_inputs;
    assign unused_inputs = ^{addr_i[WOFF-1:0], bypass_en_i};

    // ------------------------------------------------------------------ decode
    assign is_rom = addr_i[ADDR_WIDTH-1];

    // Bits between the mapped RAM range and the ROM select bit must be zero.
    if (ADDR_WIDTH - 1 > MAP_W) begin : g_unmapped
        assign unmapped = |addr_i[ADDR_WIDTH-2:MAP_W];
    end else begin : g_no_unmapped
        assign unmapped = 1'b0;
    end

    // The bank field is removed from the address to give the bank-local word.
    if (NUM_BANKS == 1) begin : g_single
        assign bank_idx   = '0;
        assign local_addr = addr_i[WOFF +: LOCAL_AW];
    end else if (INTERLEAVE != 0) begin : g_interleave
        assign bank_idx   = addr_i[WOFF +: BSEL_BITS];
        assign local_addr = addr_i[WOFF+BSEL_BITS +: LOCAL_AW];
    end else begin : g_contig
        assign bank_idx   = addr_i[BANK_AW +: BSEL_BITS];
        assign local_addr = addr_i[WOFF +: LOCAL_AW];
    end

    // --------------------------------------------------------- FSM / control
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rvalid_d   = 1'b0;
        src_d      = src_q;
        bank_sel_d = bank_sel_q;
        bank_en    = '0;
        rom_en     = 1'b0;
        gnt_o      = (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (is_rom) begin
                        if (we_i) begin
                            rvalid_d = 1'b1;
                            src_d    = SRC_ERR;
                        end else begin
                            rom_en = 1'b1;
                            src_d  = SRC_ROM;
                            if (ROM_WAIT == 0) begin
                                rvalid_d = 1'b1;
                            end else begin
                                state_d = ST_ROM_WAIT;
                                cnt_d   = 4'(ROM_WAIT);
                            end
                        end
                    end else if (unmapped) begin
                        rvalid_d = 1'b1;
                        src_d    = SRC_ERR;
                    end else begin
                        bank_en[bank_idx] = 1'b1;
                        bank_sel_d        = bank_idx;
                        rvalid_d          = 1'b1;
                        src_d             = we_i ? SRC_ZERO : SRC_BANK;
                    end
                end
            end
            ST_ROM_WAIT: begin
                // The response leaves the cycle after the count reaches 1.
                // That same cycle is IDLE again, so gnt_o rises with rvalid_o.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            src_q      <= SRC_ZERO;
            bank_sel_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so that every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            src_q      <= src_d;
            bank_sel_q <= bank_sel_d;
        end
    end

    // ------------------------------------------------------------- RAM banks
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
        logic [DATA_WIDTH-1:0] rdata_q;

        // NOTE: storage arrays and their read registers have no reset. A RAM
        // macro cannot be cleared in one cycle, and the response path masks
        // rdata until a read has actually filled it.
        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (we_i) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (be_i[i]) begin
                            mem[local_addr][i*8 +: 8] <= wdata_i[i*8 +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem[local_addr];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // --------------------------------------------------------------- boot ROM
    assign rom_word = DATA_WIDTH'(32'hB007_0000)
                    ^ DATA_WIDTH'(addr_i[ROM_ADDR_WIDTH-1:WOFF]);

    // No further ROM access is accepted before this word is returned, so it
    // holds through the wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rdata_q <= '0;
        end else if (rom_en) begin
            rom_rdata_q <= rom_word;
        end
    end

    // --------------------------------------------------------------- response
    always_comb begin
        rvalid_o = rvalid_q;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (rvalid_q) begin
            case (src_q)
                SRC_BANK: rdata_o = bank_rdata[bank_sel_q];
                SRC_ROM:  rdata_o = rom_rdata_q;
                SRC_ERR:  err_o   = 1'b1;
                default:  rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_ctrl
//
// Self-checking bench for instr_mem_ctrl with 2 word-interleaved 1 KiB banks,
// a 16-bit address (bits 14:11 unmapped) and 2 ROM wait states. Each call of
// step() covers one clock cycle: at the falling edge it compares the DUT
// outputs with a transaction-level model, then drives the next request. The
// model keeps a flat word-addressed memory, a queue of pending responses with
// their remaining latency, and a count of cycles the port stays busy.
// -----------------------------------------------------------------------------
module tb_instr_mem_ctrl;

    localparam int NUM_BANKS = 2;
    localparam int BANK_SIZE = 1024;
    localparam int AW        = 16;
    localparam int ROM_AW    = 12;
    localparam int ROM_WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        gnt_o;
    logic [15:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        bypass_en_i;

    instr_mem_ctrl #(
        .NUM_BANKS     (NUM_BANKS),
        .BANK_SIZE     (BANK_SIZE),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (AW),
        .ROM_ADDR_WIDTH(ROM_AW),
        .ROM_WAIT      (ROM_WAIT),
        .INTERLEAVE    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .bypass_en_i(bypass_en_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference
    typedef struct {
        int          ticks;  // cycles until the response should be visible
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       resp_q[$];
    int          busy_left = 0;   // cycles for which gnt_o must stay low
    logic [31:0] mem_m [int];     // RAM contents by global word index

    // One cycle: check outputs, then present a request for the next edge.
    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        resp_t       rs;
        logic [1:0]  exp_bank_en;
        logic        exp_rom_en;
        logic [31:0] word_val;
        int          word;

        @(negedge clk);
        if (busy_left > 0) busy_left--;
        foreach (resp_q[i]) resp_q[i].ticks--;

        check("gnt", 32'(gnt_o), 32'(busy_left == 0));
        if (resp_q.size() > 0 && resp_q[0].ticks == 0) begin
            rs = resp_q.pop_front();
            check("rvalid", 32'(rvalid_o), 32'd1);
            check("rdata", rdata_o, rs.data);
            check("err", 32'(err_o), 32'(rs.err));
        end else begin
            check("rvalid_quiet", 32'(rvalid_o), 32'd0);
            check("rdata_quiet", rdata_o, 32'd0);
            check("err_quiet", 32'(err_o), 32'd0);
        end

        req_i       = r;
        we_i        = w;
        addr_i      = a;
        be_i        = b;
        wdata_i     = d;
        bypass_en_i = 1'($urandom_range(0, 1));

        exp_bank_en = 2'b00;
        exp_rom_en  = 1'b0;
        if (r && busy_left == 0) begin
            rs.ticks = 1;
            rs.data  = 32'd0;
            rs.err   = 1'b0;
            if (a[15]) begin
                if (w) begin
                    rs.err = 1'b1;
                end else begin
                    exp_rom_en = 1'b1;
                    rs.data    = 32'hB007_0000 ^ 32'(a[ROM_AW-1:2]);
                    rs.ticks   = 1 + ROM_WAIT;
                    busy_left  = ROM_WAIT + 1;
                end
            end else if (a[14:11] != 4'd0) begin
                rs.err = 1'b1;
            end else begin
                word = int'(a[10:2]);
                exp_bank_en[word % NUM_BANKS] = 1'b1;
                if (w) begin
                    word_val = mem_m.exists(word) ? mem_m[word] : 32'd0;
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) word_val[i*8 +: 8] = d[i*8 +: 8];
                    end
                    mem_m[word] = word_val;
                end else begin
                    rs.data = mem_m[word];
                end
            end
            resp_q.push_back(rs);
        end

        #1;
        check("bank_en", 32'(dut.bank_en), 32'(exp_bank_en));
        check("rom_en", 32'(dut.rom_en), 32'(exp_rom_en));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    endtask

    // Words 0..7 and 504..511 cover both banks at both ends of the RAM.
    function automatic logic [15:0] pool_addr(input int idx);
        int word;
        word = (idx < 8) ? idx : 496 + idx;
        return 16'(word << 2);
    endfunction

    initial begin
        int          kind;
        logic        rw;
        logic        rr;
        logic [15:0] ra;

        rst_n       = 1'b0;
        req_i       = 1'b0;
        we_i        = 1'b0;
        addr_i      = '0;
        be_i        = '0;
        wdata_i     = '0;
        bypass_en_i = 1'b0;

        // Reset state
        #2;
        check("reset_rvalid", 32'(rvalid_o), 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_gnt", 32'(gnt_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then read back
        step(1'b1, 1'b1, 16'h0000, 4'hF, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 16'h0000, 4'hF, 32'h0);
        idle(2);

        // Interleaved banks, back-to-back reads
        step(1'b1, 1'b1, 16'h0000, 4'hF, 32'h11);
        step(1'b1, 1'b1, 16'h0004, 4'hF, 32'h22);
        step(1'b1, 1'b0, 16'h0000, 4'hF, 32'h0);
        step(1'b1, 1'b0, 16'h0004, 4'hF, 32'h0);
        idle(2);

        // Fill the random-test pool, then check a partial-byte write
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, pool_addr(i), 4'hF, $urandom);
        step(1'b1, 1'b1, pool_addr(9), 4'b0101, 32'hA5A5_A5A5);
        step(1'b1, 1'b0, pool_addr(9), 4'hF, 32'h0);
        idle(1);

        // ROM read with wait states, with req held high during the wait
        step(1'b1, 1'b0, 16'h8010, 4'hF, 32'h0);
        step(1'b1, 1'b0, pool_addr(3), 4'hF, 32'h0);
        step(1'b1, 1'b0, pool_addr(3), 4'hF, 32'h0);
        step(1'b1, 1'b0, pool_addr(3), 4'hF, 32'h0);
        idle(2);

        // ROM write and unmapped read answer with an error
        step(1'b1, 1'b1, 16'h8000, 4'hF, 32'h1234_5678);
        step(1'b1, 1'b0, 16'h0800, 4'hF, 32'h0);
        step(1'b1, 1'b0, 16'h7FFC, 4'hF, 32'h0);
        idle(2);

        // Reset while a ROM read is waiting
        step(1'b1, 1'b0, 16'h8FFC, 4'hF, 32'h0);
        idle(1);
        @(negedge clk);
        req_i = 1'b0;
        rst_n = 1'b0;
        resp_q.delete();
        busy_left = 0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_mid_gnt", 32'(gnt_o), 32'd1);
        @(negedge clk);
        check("rst_hold_rvalid", 32'(rvalid_o), 32'd0);
        rst_n = 1'b1;
        idle(3);
        step(1'b1, 1'b0, pool_addr(1), 4'hF, 32'h0);
        idle(1);

        // Random request stream
        for (int n = 0; n < 800; n++) begin
            kind = $urandom_range(0, 7);
            rr   = ($urandom_range(0, 3) != 0);
            rw   = 1'($urandom_range(0, 1));
            case (kind)
                0:       begin ra = 16'h8000 | (16'($urandom) & 16'h7FFC); rw = 1'b0; end
                1:       begin ra = 16'h8000 | (16'($urandom) & 16'h7FFC); rw = 1'b1; end
                2:       ra = (16'($urandom_range(1, 15)) << 11) | (16'($urandom) & 16'h07FC);
                default: ra = pool_addr($urandom_range(0, 15));
            endcase
            step(rr, rw, ra, 4'($urandom), $urandom);
        end

        idle(ROM_WAIT + 3);
        check("drained", 32'(resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
